// File: rtl/answer_judge_if.sv
// rtl/answer_judge_if.sv - host/button/verdict signal bundle for the answer judge
interface answer_judge_if;
  logic       start;
  logic [1:0] correctAnswer;
  logic [3:0] key_n;
  logic       w;
  logic       m;
  logic       busy;
  logic [1:0] lastChoice;
  logic       timedOut;
  logic [7:0] answerCount;
  logic [7:0] correctCount;

  modport master (
    output start, correctAnswer, key_n,
    input  w, m, busy, lastChoice, timedOut, answerCount, correctCount
  );

  modport slave (
    input  start, correctAnswer, key_n,
    output w, m, busy, lastChoice, timedOut, answerCount, correctCount
  );
endinterface

// File: rtl/answer_judge.sv
// rtl/answer_judge.sv - debounced four-button quiz judge with timeout and verdict hold
module answer_judge #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 500000000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input logic          clock,
  input logic          globalReset,
  answer_judge_if.slave bus
);
  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHOW} state_t;

  state_t      state_q, state_d;
  logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]  db_q, db_d, press_q, press_d;
  logic [31:0] deb_cnt_q [4];
  logic [31:0] deb_cnt_d [4];
  logic [31:0] tmr_q, tmr_d, hold_q, hold_d;
  logic [1:0]  ans_q, ans_d, last_q, last_d, pick;
  logic        w_q, w_d, m_q, m_d, busy_q, busy_d, to_q, to_d;
  logic [7:0]  ans_cnt_q, ans_cnt_d, cor_cnt_q, cor_cnt_d;

  // Two-flop synchroniser, per-bit debounce, and one-cycle press pulse on a debounced fall
  always_comb begin
    sync1_d = bus.key_n;
    sync2_d = sync1_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      db_d[i]      = db_q[i];
      press_d[i]   = 1'b0;
      if (sync2_q[i] == db_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_cnt_d[i] = '0;
        db_d[i]      = sync2_q[i];
        press_d[i]   = ~sync2_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 32'd1;
      end
    end
  end

  // Lowest-index press wins when several land in the same cycle
  always_comb begin
    pick = 2'd3;
    if (press_q[0])      pick = 2'd0;
    else if (press_q[1]) pick = 2'd1;
    else if (press_q[2]) pick = 2'd2;
  end

  // Question FSM: arm on start, judge first press or timeout, hold verdict, return to idle
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    hold_d    = hold_q;
    ans_d     = ans_q;
    last_d    = last_q;
    w_d       = w_q;
    m_d       = m_q;
    to_d      = to_q;
    ans_cnt_d = ans_cnt_q;
    cor_cnt_d = cor_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ans_d   = bus.correctAnswer;
          tmr_d   = '0;
          state_d = ARMED;
        end
      end
      ARMED: begin
        tmr_d = tmr_q + 32'd1;
        if (|press_q || tmr_q == TMO_LAST) begin
          state_d   = SHOW;
          hold_d    = '0;
          ans_cnt_d = (ans_cnt_q == 8'hFF) ? ans_cnt_q : ans_cnt_q + 8'd1;
          if (|press_q) begin
            last_d = pick;
            to_d   = 1'b0;
            m_d    = (pick == ans_q);
            w_d    = (pick != ans_q);
            if (pick == ans_q && cor_cnt_q != 8'hFF) cor_cnt_d = cor_cnt_q + 8'd1;
          end else begin
            to_d = 1'b1;
            w_d  = 1'b1;
            m_d  = 1'b0;
          end
        end
      end
      SHOW: begin
        if (hold_q == HOLD_LAST) begin
          w_d     = 1'b0;
          m_d     = 1'b0;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset leaves buttons released and aborts any question
  always_ff @(posedge clock or posedge globalReset) begin
    if (globalReset) begin
      state_q   <= IDLE;
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      db_q      <= 4'hF;
      press_q   <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      tmr_q     <= '0;
      hold_q    <= '0;
      ans_q     <= '0;
      last_q    <= '0;
      w_q       <= 1'b0;
      m_q       <= 1'b0;
      to_q      <= 1'b0;
      busy_q    <= 1'b0;
      ans_cnt_q <= '0;
      cor_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      press_q   <= press_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      tmr_q     <= tmr_d;
      hold_q    <= hold_d;
      ans_q     <= ans_d;
      last_q    <= last_d;
      w_q       <= w_d;
      m_q       <= m_d;
      to_q      <= to_d;
      busy_q    <= busy_d;
      ans_cnt_q <= ans_cnt_d;
      cor_cnt_q <= cor_cnt_d;
    end
  end

  assign bus.w            = w_q;
  assign bus.m            = m_q;
  assign bus.busy         = busy_q;
  assign bus.lastChoice   = last_q;
  assign bus.timedOut     = to_q;
  assign bus.answerCount  = ans_cnt_q;
  assign bus.correctCount = cor_cnt_q;
endmodule

// File: tb/tb_answer_judge.sv
// tb/tb_answer_judge.sv - randomized self-checking bench for answer_judge
module tb_answer_judge;
  localparam int DEB = 4;
  localparam int TMO = 100;
  localparam int HLD = 20;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  int       exp_ans = 0;
  int       exp_cor = 0;
  logic [1:0] exp_last = 2'd0;

  answer_judge_if intf();

  answer_judge #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .HOLD_CYCLES(HLD)) dut (
    .clock(clock),
    .globalReset(rst),
    .bus(intf)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One question: optional glitch on key 0, then press mask (0 = let it time out)
  task automatic run_question(input logic [1:0] ca, input logic [3:0] mask, input bit glitch);
    int n;
    int hold;
    bit stable;
    logic [1:0] idx;
    logic ew, em, eto;
    logic sw, sm;
    n_cmp++;
    if (intf.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %0b want 0", intf.busy); end
    intf.correctAnswer = ca;
    intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    n_cmp++;
    if (intf.busy !== 1'b1) begin n_err++; $display("FAIL armed_busy: got %0b want 1", intf.busy); end
    n = 0;
    if (glitch) begin
      intf.key_n = 4'b1110;
      tick(); tick();
      intf.key_n = 4'hF;
      repeat (8) tick();
      n = 10;
      n_cmp++;
      if ((intf.w | intf.m) !== 1'b0 || intf.busy !== 1'b1) begin
        n_err++; $display("FAIL glitch_event: w=%0b m=%0b busy=%0b want 0 0 1", intf.w, intf.m, intf.busy);
      end
    end
    intf.key_n = ~mask;
    while (!(intf.w | intf.m) && n < TMO + 50) begin tick(); n++; end
    n_cmp++;
    if (!(intf.w | intf.m)) begin n_err++; $display("FAIL verdict_wait: no verdict after %0d cycles", n); end
    if (mask == 4'd0) begin
      n_cmp++;
      if (n != TMO) begin n_err++; $display("FAIL timeout_latency: got %0d want %0d", n, TMO); end
      ew = 1'b1; em = 1'b0; eto = 1'b1;
    end else begin
      idx = 2'd0;
      while (!mask[idx]) idx++;
      em = (idx == ca); ew = !em; eto = 1'b0;
      exp_last = idx;
      if (em && exp_cor < 255) exp_cor++;
    end
    if (exp_ans < 255) exp_ans++;
    n_cmp++;
    if (intf.w !== ew || intf.m !== em) begin
      n_err++; $display("FAIL verdict: w=%0b m=%0b want w=%0b m=%0b", intf.w, intf.m, ew, em);
    end
    n_cmp++;
    if (intf.lastChoice !== exp_last) begin n_err++; $display("FAIL last_choice: got %0d want %0d", intf.lastChoice, exp_last); end
    n_cmp++;
    if (intf.timedOut !== eto) begin n_err++; $display("FAIL timed_out: got %0b want %0b", intf.timedOut, eto); end
    n_cmp++;
    if (intf.answerCount !== 8'(exp_ans) || intf.correctCount !== 8'(exp_cor)) begin
      n_err++; $display("FAIL counts: got %0d/%0d want %0d/%0d", intf.answerCount, intf.correctCount, exp_ans, exp_cor);
    end
    sw = intf.w; sm = intf.m;
    hold = 1; stable = 1'b1;
    tick();
    while ((intf.w | intf.m) && hold < HLD + 10) begin
      if (intf.w !== sw || intf.m !== sm || intf.busy !== 1'b1) stable = 1'b0;
      hold++;
      tick();
    end
    n_cmp++;
    if (hold != HLD) begin n_err++; $display("FAIL hold_len: got %0d want %0d", hold, HLD); end
    n_cmp++;
    if (!stable || intf.busy !== 1'b0) begin
      n_err++; $display("FAIL hold_shape: stable=%0b busy_after=%0b want 1 0", stable, intf.busy);
    end
    intf.key_n = 4'hF;
    repeat (10) tick();
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({intf.w, intf.m, intf.busy, intf.timedOut, intf.lastChoice, intf.answerCount, intf.correctCount} !== 23'd0) begin
      n_err++; $display("FAIL reset_outputs: w=%0b m=%0b busy=%0b to=%0b last=%0d ans=%0d cor=%0d want all 0",
        intf.w, intf.m, intf.busy, intf.timedOut, intf.lastChoice, intf.answerCount, intf.correctCount);
    end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_directed;
    run_question(2'd2, 4'b0100, 1'b0);
    run_question(2'd0, 4'b1000, 1'b0);
    run_question(2'd3, 4'b0000, 1'b0);
    run_question(2'd1, 4'b1010, 1'b1);
  endtask

  task automatic test_ignore;
    int n;
    int hold;
    intf.key_n = 4'b1110;
    repeat (12) tick();
    n_cmp++;
    if ({intf.w, intf.m, intf.busy} !== 3'b000 || intf.answerCount !== 8'(exp_ans)) begin
      n_err++; $display("FAIL idle_press: w=%0b m=%0b busy=%0b ans=%0d want 0 0 0 %0d", intf.w, intf.m, intf.busy, intf.answerCount, exp_ans);
    end
    intf.key_n = 4'hF;
    repeat (10) tick();
    intf.correctAnswer = 2'd0;
    intf.start = 1'b1;
    tick();
    n = 0;
    while (!(intf.w | intf.m) && n < TMO + 50) begin
      intf.start = (n == 30);
      tick();
      n++;
    end
    intf.start = 1'b0;
    if (exp_ans < 255) exp_ans++;
    n_cmp++;
    if (n != TMO || intf.timedOut !== 1'b1 || intf.w !== 1'b1) begin
      n_err++; $display("FAIL rearm_ignored: latency=%0d to=%0b w=%0b want %0d 1 1", n, intf.timedOut, intf.w, TMO);
    end
    intf.key_n = 4'b1011;
    intf.start = 1'b1;
    hold = 1;
    tick();
    intf.start = 1'b0;
    while ((intf.w | intf.m) && hold < HLD + 10) begin hold++; tick(); end
    n_cmp++;
    if (hold != HLD) begin n_err++; $display("FAIL show_press_hold: got %0d want %0d", hold, HLD); end
    repeat (12) tick();
    n_cmp++;
    if ({intf.w, intf.m, intf.busy} !== 3'b000 || intf.lastChoice !== exp_last || intf.answerCount !== 8'(exp_ans)) begin
      n_err++; $display("FAIL show_ignored: w=%0b m=%0b busy=%0b last=%0d ans=%0d want 0 0 0 %0d %0d",
        intf.w, intf.m, intf.busy, intf.lastChoice, intf.answerCount, exp_last, exp_ans);
    end
    intf.key_n = 4'hF;
    repeat (10) tick();
  endtask

  task automatic test_saturation;
    logic [3:0] mask;
    while (exp_ans < 255) begin
      mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 15) == 0) mask = 4'd0;
      run_question(2'($urandom_range(0, 3)), mask, 1'b0);
    end
    run_question(2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), 1'b0);
    n_cmp++;
    if (intf.answerCount !== 8'd255) begin n_err++; $display("FAIL answer_sat: got %0d want 255", intf.answerCount); end
  endtask

  task automatic test_reset_mid;
    intf.correctAnswer = 2'd1;
    intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (intf.busy !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy: got %0b want 1", intf.busy); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({intf.w, intf.m, intf.busy, intf.timedOut, intf.lastChoice, intf.answerCount, intf.correctCount} !== 23'd0) begin
      n_err++; $display("FAIL async_reset: busy=%0b last=%0d ans=%0d cor=%0d want all 0",
        intf.busy, intf.lastChoice, intf.answerCount, intf.correctCount);
    end
    exp_ans = 0; exp_cor = 0; exp_last = 2'd0;
    tick(); tick();
    rst = 1'b0;
    intf.key_n = 4'b1101;
    repeat (30) tick();
    n_cmp++;
    if ({intf.w, intf.m, intf.busy} !== 3'b000 || intf.answerCount !== 8'd0) begin
      n_err++; $display("FAIL post_reset_press: w=%0b m=%0b busy=%0b ans=%0d want 0 0 0 0", intf.w, intf.m, intf.busy, intf.answerCount);
    end
    intf.key_n = 4'hF;
    repeat (5) tick();
  endtask

  initial begin
    intf.start = 1'b0;
    intf.correctAnswer = 2'd0;
    intf.key_n = 4'hF;
    rst = 1'b1;
    repeat (3) tick();
    test_reset();
    test_directed();
    test_ignore();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
